// File: rtl/tpic_frame_shifter.sv
// Serialises a WIDTH-bit relay image into a daisy-chained TPIC shift-register string,
// latches it with an RCK pulse and verifies the chain by reading back its serial output.
module tpic_frame_shifter #(
    parameter int unsigned WIDTH      = 300,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned RCK_CYCLES = 2,
    parameter int unsigned VERIFY     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic             auto_update,
    input  logic             err_clr,
    input  logic             sin,
    output logic             sclk,
    output logic             sout,
    output logic             rck,
    output logic             en_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] readback,
    output logic             chain_ok,
    output logic             chain_err,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned MAX_PH = (CLK_DIV > RCK_CYCLES) ? CLK_DIV : RCK_CYCLES;
    localparam int unsigned PH_W   = $clog2(MAX_PH + 1);
    localparam int unsigned BIT_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT_LO = 2'd1,
        S_SHIFT_HI = 2'd2,
        S_RCK      = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   snap_q, snap_d;
    logic [WIDTH-1:0]   shipped_q, shipped_d;
    logic [WIDTH-1:0]   rb_sh_q, rb_sh_d;
    logic [WIDTH-1:0]   readback_q, readback_d;
    logic               sclk_q, sclk_d;
    logic               sout_q, sout_d;
    logic               rck_q, rck_d;
    logic               en_n_q, en_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               chain_ok_q, chain_ok_d;
    logic               chain_err_q, chain_err_d;
    logic               pending_q, pending_d;
    logic               prev_valid_q, prev_valid_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               trigger;
    logic               ph_last;
    logic               bit_last;
    logic               frame_end;
    logic               err_set;

    assign trigger   = start | pending_q | (auto_update & (data != shipped_q));
    assign ph_last   = (state_q == S_RCK) ? (ph_q == PH_W'(RCK_CYCLES - 1))
                                          : (ph_q == PH_W'(CLK_DIV - 1));
    assign bit_last  = (bit_q == BIT_W'(WIDTH - 1));
    assign frame_end = (state_q == S_RCK) & ph_last;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (trigger) state_d = S_SHIFT_LO;
            S_SHIFT_LO: if (ph_last) state_d = S_SHIFT_HI;
            S_SHIFT_HI: if (ph_last) state_d = bit_last ? S_RCK : S_SHIFT_LO;
            S_RCK:      if (ph_last) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        ph_d         = ph_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        snap_d       = snap_q;
        shipped_d    = shipped_q;
        rb_sh_d      = rb_sh_q;
        readback_d   = readback_q;
        en_n_d       = en_n_q;
        chain_ok_d   = chain_ok_q;
        pending_d    = pending_q;
        prev_valid_d = prev_valid_q;
        frame_cnt_d  = frame_cnt_q;
        err_set      = 1'b0;

        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + PH_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    shreg_d   = data;
                    snap_d    = data;
                    bit_d     = '0;
                    pending_d = 1'b0;
                end
            end
            S_SHIFT_LO: begin
                if (ph_last) rb_sh_d = {rb_sh_q[WIDTH-2:0], sin};
            end
            S_SHIFT_HI: begin
                if (ph_last) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_d   = bit_q + BIT_W'(1);
                end
            end
            default: ;
        endcase

        if ((state_q != S_IDLE) && start) pending_d = 1'b1;

        // Frame completion: commit image, publish readback, run chain check
        if (frame_end) begin
            shipped_d    = snap_q;
            readback_d   = rb_sh_q;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            en_n_d       = 1'b0;
            prev_valid_d = 1'b1;
            if (VERIFY != 0) begin
                if (prev_valid_q) begin
                    chain_ok_d = (rb_sh_q == shipped_q);
                    err_set    = (rb_sh_q != shipped_q);
                end else begin
                    chain_ok_d = 1'b0;
                end
            end
        end

        if (err_set) begin
            chain_err_d = 1'b1;
        end else if (err_clr) begin
            chain_err_d = 1'b0;
        end else begin
            chain_err_d = chain_err_q;
        end

        done_d = frame_end;
        busy_d = (state_d != S_IDLE);
        sclk_d = (state_d == S_SHIFT_HI);
        rck_d  = (state_d == S_RCK);
        sout_d = (state_d == S_SHIFT_LO) ? shreg_d[WIDTH-1] : sout_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_q         <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            snap_q       <= '0;
            shipped_q    <= '0;
            rb_sh_q      <= '0;
            readback_q   <= '0;
            sclk_q       <= 1'b0;
            sout_q       <= 1'b0;
            rck_q        <= 1'b0;
            en_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            chain_ok_q   <= 1'b0;
            chain_err_q  <= 1'b0;
            pending_q    <= 1'b0;
            prev_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            ph_q         <= ph_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            snap_q       <= snap_d;
            shipped_q    <= shipped_d;
            rb_sh_q      <= rb_sh_d;
            readback_q   <= readback_d;
            sclk_q       <= sclk_d;
            sout_q       <= sout_d;
            rck_q        <= rck_d;
            en_n_q       <= en_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            chain_ok_q   <= chain_ok_d;
            chain_err_q  <= chain_err_d;
            pending_q    <= pending_d;
            prev_valid_q <= prev_valid_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign sclk      = sclk_q;
    assign sout      = sout_q;
    assign rck       = rck_q;
    assign en_n      = en_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign readback  = readback_q;
    assign chain_ok  = chain_ok_q;
    assign chain_err = chain_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
